y4_pack_ctrl: RTL and testbench
===============================

Name: y4_pack_ctrl

Overview:
- Streaming controller that sequences RGB666-to-Y4 luma conversion for the incoming video path.
- Accepts one RGB666 pixel per handshake and computes 4-bit luma. Packs four pixels per 16-bit word and tracks line/frame position.
- Emits words with end-of-line/end-of-frame markers to the downstream framebuffer writer.
- Sits between the video input front end and the framebuffer write FIFO. Applies backpressure in both directions.

Parameters:
H_ACTIVE, 1600, active pixels per line (>=1)
V_ACTIVE, 1200, active lines per frame (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  pixel present on in_r/in_g/in_b
in_ready  output  1  pixel accepted when in_valid && in_ready
in_sof  input  1  qualifies the current pixel as first of frame (sampled only on accept)
in_r  input  6  red
in_g  input  6  green
in_b  input  6  blue
out_valid  output  1  word present
out_ready  input  1  downstream accepts when out_valid && out_ready
out_data  output  16  packed luma, pixel n of word at bits [4n+3:4n]
out_eol  output  1  word is last of a line (qualified by out_valid)
out_eof  output  1  word is last of a frame (qualified by out_valid)
sync_err  output  1  sticky: in_sof seen away from frame origin

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous and active-high.
  - On rst: out_valid=0, out_data=0, out_eol=0, out_eof=0, sync_err=0.
  - On rst: x counter=0, y counter=0, pack slot=0, pack accumulator=0.
  - rst mid-word discards the partial word and any held output word.
- Luma arithmetic, all 6-bit unsigned:
  - sum = (r>>2) + (g>>1) + (b>>2); maximum 61, no overflow.
  - Y = sum[5:2].
- Input handshake:
  - in_ready = !out_valid || out_ready.
  - in_ready does not depend on in_valid.
- Accept step (in_valid && in_ready):
  - If in_sof is set: treat the pixel as x=0, y=0. The pack slot restarts at 0 and any partial accumulator contents are dropped.
  - Write Y into slot s of the accumulator. Lower slots are kept; higher slots are cleared to 0.
  - Word close: the word closes when s==3 or x==H_ACTIVE-1.
  - On close: next cycle out_valid=1 and out_data=accumulator, with unfilled slots zero.
  - On close: out_eol=(x==H_ACTIVE-1); out_eof=out_eol && (y==V_ACTIVE-1).
  - On close: the slot resets to 0.
  - Otherwise the slot increments.
- Position counters:
  - x increments on each accept and wraps to 0 after H_ACTIVE-1. On wrap, y increments and wraps to 0 after V_ACTIVE-1.
  - The slot also restarts at 0 at each line start. Words never straddle lines.
- Latency and throughput:
  - Latency is 1 cycle from the accept of the closing pixel to out_valid.
  - Throughput is 1 pixel/clk when out_ready is held high.
- Output register:
  - out_data/out_eol/out_eof hold stable while out_valid && !out_ready.
  - out_valid drops the cycle after the handshake unless a new word closes in that same cycle, in which case it stays high with new contents.
- sync_err:
  - Set when an accepted pixel has in_sof=1 while (x,y)!=(0,0).
  - Cleared only by rst. The frame still resyncs as described above.
  - in_sof at the true origin is legal and has no effect.
- in_sof is ignored when the pixel is not accepted.
- in_r/in_g/in_b are don't-care when in_valid=0.

Test Plan:
- Reset values: hold rst 3 cycles with in_valid=1 -> all outputs 0 throughout reset. in_ready=1 on the first cycle after rst.
- Luma corners: H_ACTIVE=4, V_ACTIVE=1. Pixels (63,63,63), (0,0,0), (63,0,0), (0,63,0) with in_sof on the first -> one word 0x730F with out_eol=1, out_eof=1, 1 cycle after the 4th accept.
- Line padding: H_ACTIVE=6, V_ACTIVE=2. All pixels b=32 (Y=2), 12 pixels, out_ready=1 -> words 0x2222 (eol0), 0x0022 (eol1, eof0), 0x2222, 0x0022 (eol1, eof1).
- Backpressure: out_ready=0 for 5 cycles after the first word -> out_data stable; in_ready=0 while the word is held; no pixel lost; the sequence matches the unstalled run.
- Resync: H_ACTIVE=6. in_sof asserted on the 3rd pixel of a line -> sync_err=1. The 2 earlier pixels are discarded. The next word packs the sof pixel into slot 0. Line/frame markers restart from that pixel.
- Reset mid-word: accept 2 pixels, pulse rst, send 4 pixels with in_sof -> exactly one word containing only the new 4 pixels; sync_err=0.

Source files
------------

// File: rtl/y4_pack_ctrl_if.sv
// Pixel-in / word-out handshake bundle for the Y4 luma packer.
// slave is the packer side, master is the driver/monitor side.
interface y4_pack_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [5:0]  in_r;
    logic [5:0]  in_g;
    logic [5:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_eol;
    logic        out_eof;
    logic        sync_err;

    modport slave (
        input  in_valid, in_sof, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_data, out_eol, out_eof, sync_err
    );

    modport master (
        output in_valid, in_sof, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_eol, out_eof, sync_err
    );
endinterface

// File: rtl/y4_pack_ctrl.sv
// RGB666 -> 4-bit luma converter that packs four pixels per 16-bit word,
// tracks line/frame position and flags end-of-line/end-of-frame words.
module y4_pack_ctrl #(
    parameter int unsigned H_ACTIVE = 1600,
    parameter int unsigned V_ACTIVE = 1200
) (
    input  logic             clk,
    input  logic             rst,
    y4_pack_ctrl_if.slave    bus
);
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_slot;
    logic [15:0]   r_acc;
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_eol;
    logic          r_out_eof;
    logic          r_sync_err;

    logic          w_in_ready;
    logic          w_accept;
    logic [5:0]    w_sum;
    logic [3:0]    w_luma;
    logic [XW-1:0] w_x_eff;
    logic [YW-1:0] w_y_eff;
    logic [1:0]    w_slot_eff;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_close;
    logic [15:0]   w_acc_next;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_sum  = {2'b00, bus.in_r[5:2]} + {1'b0, bus.in_g[5:1]} + {2'b00, bus.in_b[5:2]};
    assign w_luma = w_sum[5:2];

    // in_sof forces the pixel to the frame origin and drops any partial word
    assign w_x_eff    = bus.in_sof ? '0 : r_x;
    assign w_y_eff    = bus.in_sof ? '0 : r_y;
    assign w_slot_eff = bus.in_sof ? '0 : r_slot;

    assign w_x_last = (w_x_eff == XW'(H_ACTIVE - 1));
    assign w_y_last = (w_y_eff == YW'(V_ACTIVE - 1));
    assign w_close  = (w_slot_eff == 2'd3) || w_x_last;

    always_comb begin
        w_acc_next = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < {30'd0, w_slot_eff})
                w_acc_next[4*i +: 4] = r_acc[4*i +: 4];
            else if (i == {30'd0, w_slot_eff})
                w_acc_next[4*i +: 4] = w_luma;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_slot      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (bus.in_sof && ((r_x != '0) || (r_y != '0)))
                    r_sync_err <= 1'b1;

                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : w_y_eff + YW'(1);
                end else begin
                    r_x <= w_x_eff + XW'(1);
                    r_y <= w_y_eff;
                end

                if (w_close) begin
                    r_slot <= '0;
                    r_acc  <= '0;
                end else begin
                    r_slot <= w_slot_eff + 2'd1;
                    r_acc  <= w_acc_next;
                end
            end

            // a closing accept reloads the output even in the cycle it is drained
            if (w_accept && w_close) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
                r_out_eol   <= w_x_last;
                r_out_eof   <= w_x_last && w_y_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_eol   = r_out_eol;
    assign bus.out_eof   = r_out_eof;
    assign bus.sync_err  = r_sync_err;
endmodule

// File: tb/tb_y4_pack_ctrl.sv
// Bench for y4_pack_ctrl: frame-position reference model plus directed literal cases.
module tb_y4_pack_ctrl;
    localparam int unsigned HB = 6;
    localparam int unsigned VB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y4_pack_ctrl_if ifa ();
    y4_pack_ctrl_if ifb ();

    y4_pack_ctrl #(.H_ACTIVE(4), .V_ACTIVE(1)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    y4_pack_ctrl #(.H_ACTIVE(HB), .V_ACTIVE(VB)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;

    // model state: position as a linear pixel index within the frame
    int unsigned   m_p = 0;
    logic [3:0]    m_pend[$];
    logic [17:0]   exp_q[$];
    logic [17:0]   obs_q[$];
    logic          exp_sync = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [3:0] luma(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        int unsigned s;
        s = (int'(r) / 4) + (int'(g) / 2) + (int'(b) / 4);
        return 4'(s / 4);
    endfunction

    task automatic model_accept(input logic [3:0] y, input logic sof);
        int unsigned x, ln;
        logic [15:0] w;
        if (sof) begin
            if (m_p != 0) exp_sync = 1'b1;
            m_p = 0;
            m_pend.delete();
        end
        x  = m_p % HB;
        ln = m_p / HB;
        m_pend.push_back(y);
        if (m_pend.size() == 4 || x == HB - 1) begin
            w = '0;
            foreach (m_pend[i]) w[4*i +: 4] = m_pend[i];
            exp_q.push_back({(x == HB - 1), (x == HB - 1) && (ln == VB - 1), w});
            m_pend.delete();
        end
        m_p = (m_p + 1) % (HB * VB);
    endtask

    // compare process for instance B
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, ifb.in_ready}, {31'd0, (!ifb.out_valid || ifb.out_ready)});
            chk("sync_err", {31'd0, ifb.sync_err}, {31'd0, exp_sync});
            chk("out_valid", {31'd0, ifb.out_valid}, {31'd0, exp_q.size() != 0});
            if (ifb.out_valid && exp_q.size() != 0) begin
                chk("out_data", {16'd0, ifb.out_data}, {16'd0, exp_q[0][15:0]});
                chk("out_eol", {31'd0, ifb.out_eol}, {31'd0, exp_q[0][17]});
                chk("out_eof", {31'd0, ifb.out_eof}, {31'd0, exp_q[0][16]});
            end
            if (rst) begin
                m_p = 0;
                m_pend.delete();
                exp_q.delete();
                exp_sync = 1'b0;
            end else begin
                if (ifb.out_valid && ifb.out_ready) begin
                    obs_q.push_back({ifb.out_eol, ifb.out_eof, ifb.out_data});
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (ifb.in_valid && ifb.in_ready)
                    model_accept(luma(ifb.in_r, ifb.in_g, ifb.in_b), ifb.in_sof);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            ifb.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_b(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b, input logic sof);
        bit done = 1'b0;
        int unsigned n = 0;
        ifb.in_valid = 1'b1;
        ifb.in_sof   = sof;
        ifb.in_r = r; ifb.in_g = g; ifb.in_b = b;
        while (!done) begin
            @(negedge clk);
            done = ifb.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        ifb.in_valid = 1'b0;
        ifb.in_sof   = 1'b0;
        ifb.in_r = 6'($urandom); ifb.in_g = 6'($urandom); ifb.in_b = 6'($urandom);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || ifb.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {31'd0, ifb.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input int idx, input logic [15:0] d, input logic eol, input logic eof);
        if (obs_q.size() > idx) begin
            chk("obs_data", {16'd0, obs_q[idx][15:0]}, {16'd0, d});
            chk("obs_eol", {31'd0, obs_q[idx][17]}, {31'd0, eol});
            chk("obs_eof", {31'd0, obs_q[idx][16]}, {31'd0, eof});
        end else begin
            chk("obs_missing", obs_q.size(), idx + 1);
        end
    endtask

    task automatic padding_run();
        obs_q.delete();
        for (int i = 0; i < 12; i++) push_b(6'd0, 6'd0, 6'd32, (i == 0));
        drain();
        chk("pad_words", obs_q.size(), 4);
        check_obs(0, 16'h2222, 1'b0, 1'b0);
        check_obs(1, 16'h0022, 1'b1, 1'b0);
        check_obs(2, 16'h2222, 1'b0, 1'b0);
        check_obs(3, 16'h0022, 1'b1, 1'b1);
    endtask

    initial begin
        logic [15:0] held;
        int unsigned n;

        ifa.in_valid = 1'b1; ifa.in_sof = 1'b0; ifa.out_ready = 1'b1;
        ifa.in_r = 6'd63; ifa.in_g = 6'd63; ifa.in_b = 6'd63;
        ifb.in_valid = 1'b1; ifb.in_sof = 1'b0; ifb.out_ready = 1'b1;
        ifb.in_r = 6'd63; ifb.in_g = 6'd63; ifb.in_b = 6'd63;

        // reset held 3 cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            chk("rst_valid_a", {31'd0, ifa.out_valid}, 32'd0);
            chk("rst_data_a", {16'd0, ifa.out_data}, 32'd0);
            chk("rst_flags_a", {29'd0, ifa.out_eol, ifa.out_eof, ifa.sync_err}, 32'd0);
            chk("rst_data_b", {16'd0, ifb.out_data}, 32'd0);
            chk("rst_flags_b", {29'd0, ifb.out_eol, ifb.out_eof, ifb.sync_err}, 32'd0);
        end
        rst = 1'b0;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst_a", {31'd0, ifa.in_ready}, 32'd1);
        chk("ready_after_rst_b", {31'd0, ifb.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // luma corners on the 4x1 instance
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_sof   = (i == 0);
            case (i)
                0: begin ifa.in_r = 6'd63; ifa.in_g = 6'd63; ifa.in_b = 6'd63; end
                1: begin ifa.in_r = 6'd0;  ifa.in_g = 6'd0;  ifa.in_b = 6'd0;  end
                2: begin ifa.in_r = 6'd63; ifa.in_g = 6'd0;  ifa.in_b = 6'd0;  end
                default: begin ifa.in_r = 6'd0; ifa.in_g = 6'd63; ifa.in_b = 6'd0; end
            endcase
            @(posedge clk);
            #1;
            if (i == 2) chk("corner_early", {31'd0, ifa.out_valid}, 32'd0);
        end
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        chk("corner_valid", {31'd0, ifa.out_valid}, 32'd1);
        chk("corner_data", {16'd0, ifa.out_data}, 32'h730F);
        chk("corner_eol", {31'd0, ifa.out_eol}, 32'd1);
        chk("corner_eof", {31'd0, ifa.out_eof}, 32'd1);
        @(posedge clk);
        #1;
        chk("corner_drop", {31'd0, ifa.out_valid}, 32'd0);

        // line padding, unstalled
        padding_run();

        // same sequence with the first word held for 5 cycles
        ifb.out_ready = 1'b0;
        fork
            padding_run();
            begin
                n = 0;
                while (!ifb.out_valid && n < 100) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                chk("stall_seen", {31'd0, ifb.out_valid}, 32'd1);
                held = ifb.out_data;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #2;
                    chk("stall_hold", {16'd0, ifb.out_data}, {16'd0, held});
                    chk("stall_in_ready", {31'd0, ifb.in_ready}, 32'd0);
                end
                ifb.out_ready = 1'b1;
            end
        join

        // resync: sof on the 3rd pixel of a line
        obs_q.delete();
        push_b(6'd0, 6'd0, 6'd32, 1'b1);
        push_b(6'd0, 6'd0, 6'd32, 1'b0);
        push_b(6'd63, 6'd63, 6'd63, 1'b1);
        for (int i = 0; i < 5; i++) push_b(6'd0, 6'd0, 6'd32, 1'b0);
        drain();
        chk("resync_err", {31'd0, ifb.sync_err}, 32'd1);
        chk("resync_words", obs_q.size(), 2);
        check_obs(0, 16'h222F, 1'b0, 1'b0);
        check_obs(1, 16'h0022, 1'b1, 1'b0);

        // reset mid-word
        obs_q.delete();
        push_b(6'd0, 6'd0, 6'd32, 1'b1);
        push_b(6'd0, 6'd0, 6'd32, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push_b(6'd63, 6'd63, 6'd63, (i == 0));
        drain();
        chk("midrst_words", obs_q.size(), 1);
        check_obs(0, 16'hFFFF, 1'b0, 1'b0);
        chk("midrst_sync", {31'd0, ifb.sync_err}, 32'd0);

        // randomized traffic with random backpressure and occasional stray sof
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push_b(6'($urandom), 6'($urandom), 6'($urandom),
                   (i == 0) || ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        ifb.out_ready = 1'b1;
        drain();
        chk("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
